// File: rtl/pc_unit.sv
// pc_unit -- fetch program counter with branch/jump redirect and target checking.
//
// Every non-stalled rising edge loads pc with the next fetch address:
// sequential (pc + 4), a taken branch, a J/JAL jump or a JR/JALR register
// jump. A redirect whose target is misaligned or outside the text window
// [TEXT_LO, TEXT_HI] sends pc to EXC_VEC and raises addr_err for one cycle.
// Sequential fetches are never range-checked.
//
// Ports:
//   clk       in   1  rising-edge clock
//   reset     in   1  synchronous active-high reset (overrides stall)
//   stall     in   1  hold pc/fetch_cnt, drop any redirect this cycle
//   npc_sel   in   2  00 seq, 01 branch, 10 jump, 11 register jump
//   br_taken  in   1  branch outcome, used only when npc_sel = 01
//   pc_d      in  32  PC of the D-stage instruction
//   imm16     in  16  branch offset (words, signed)
//   imm26     in  26  jump index
//   rs_val    in  32  forwarded GPR[rs] for register jumps
//   pc        out 32  registered fetch address
//   pc_link   out 32  pc_d + 8, combinational link value
//   addr_err  out  1  registered one-cycle illegal-target pulse
//   fetch_cnt out 32  registered count of pc updates (wraps)
module pc_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC  = 32'h0000_4180,
    parameter logic [31:0] TEXT_LO  = 32'h0000_3000,
    parameter logic [31:0] TEXT_HI  = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  npc_sel,
    input  logic        br_taken,
    input  logic [31:0] pc_d,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] rs_val,
    output logic [31:0] pc,
    output logic [31:0] pc_link,
    output logic        addr_err,
    output logic [31:0] fetch_cnt
);

    logic [31:0] seq;
    logic [31:0] base;
    logic [31:0] br_off;
    logic [31:0] target;
    logic        redirect;
    logic        illegal;
    logic [31:0] npc;

    assign seq     = pc + 32'd4;
    assign base    = pc_d + 32'd4;
    assign br_off  = {{14{imm16[15]}}, imm16, 2'b00};
    assign pc_link = pc_d + 32'd8;

    always_comb begin
        target   = seq;
        redirect = 1'b0;
        unique case (npc_sel)
            2'b00: begin
                target   = seq;
                redirect = 1'b0;
            end
            2'b01: begin
                // An untaken branch is just a sequential fetch, not a redirect.
                target   = br_taken ? (base + br_off) : seq;
                redirect = br_taken;
            end
            2'b10: begin
                target   = {base[31:28], imm26, 2'b00};
                redirect = 1'b1;
            end
            2'b11: begin
                target   = rs_val;
                redirect = 1'b1;
            end
            default: begin
                target   = seq;
                redirect = 1'b0;
            end
        endcase
    end

    assign illegal = redirect &&
                     ((target[1:0] != 2'b00) || (target < TEXT_LO) || (target > TEXT_HI));
    assign npc     = illegal ? EXC_VEC : target;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= PC_RESET;
            addr_err  <= 1'b0;
            fetch_cnt <= '0;
        end else if (stall) begin
            // Redirects under stall are dropped; D stage re-presents them.
            addr_err  <= 1'b0;
        end else begin
            pc        <= npc;
            addr_err  <= illegal;
            fetch_cnt <= fetch_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit -- directed-vector bench for pc_unit with a behavioural model
// and hand-computed pinned expectations checked on the falling edge.
module tb_pc_unit;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC  = 32'h0000_4180;
    localparam logic [31:0] TEXT_LO  = 32'h0000_3000;
    localparam logic [31:0] TEXT_HI  = 32'h0000_6FFC;

    logic        clk = 1'b0;
    logic        reset, stall, br_taken;
    logic [1:0]  npc_sel;
    logic [31:0] pc_d, rs_val;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] pc, pc_link, fetch_cnt;
    logic        addr_err;

    pc_unit #(
        .PC_RESET(PC_RESET),
        .EXC_VEC (EXC_VEC),
        .TEXT_LO (TEXT_LO),
        .TEXT_HI (TEXT_HI)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .npc_sel  (npc_sel),
        .br_taken (br_taken),
        .pc_d     (pc_d),
        .imm16    (imm16),
        .imm26    (imm26),
        .rs_val   (rs_val),
        .pc       (pc),
        .pc_link  (pc_link),
        .addr_err (addr_err),
        .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc, m_cnt, m_t;
    logic        m_err, m_redir, m_bad;
    int          m_off;

    always @(posedge clk) begin
        if (reset) begin
            m_pc  = PC_RESET;
            m_err = 1'b0;
            m_cnt = 32'd0;
        end else if (stall) begin
            m_err = 1'b0;
        end else begin
            m_redir = 1'b1;
            if (npc_sel == 2'd0 || (npc_sel == 2'd1 && !br_taken)) begin
                m_t     = m_pc + 32'd4;
                m_redir = 1'b0;
            end else if (npc_sel == 2'd1) begin
                m_off = int'($signed(imm16)) * 4;
                m_t   = pc_d + 32'd4 + 32'(m_off);
            end else if (npc_sel == 2'd2) begin
                m_t = ((pc_d + 32'd4) & 32'hF000_0000) + 32'(imm26) * 32'd4;
            end else begin
                m_t = rs_val;
            end
            m_bad = m_redir && ((m_t % 32'd4) != 32'd0 || m_t < TEXT_LO || m_t > TEXT_HI);
            m_pc  = m_bad ? EXC_VEC : m_t;
            m_err = m_bad;
            m_cnt = m_cnt + 32'd1;
        end
    end

    // ---------------- compare process ----------------
    int          vectors = 0;
    int          miscompares = 0;
    logic        chk_en = 1'b0;
    logic        lit_en = 1'b0;
    logic [31:0] lit_pc, lit_cnt, lit_link;
    logic        lit_err;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("pc", pc, m_pc);
            check("addr_err", {31'b0, addr_err}, {31'b0, m_err});
            check("fetch_cnt", fetch_cnt, m_cnt);
            check("pc_link", pc_link, pc_d + 32'd8);
            if (lit_en) begin
                check("pin_pc", pc, lit_pc);
                check("pin_addr_err", {31'b0, addr_err}, {31'b0, lit_err});
                check("pin_fetch_cnt", fetch_cnt, lit_cnt);
                check("pin_pc_link", pc_link, lit_link);
                check("model_pin_pc", m_pc, lit_pc);
                check("model_pin_cnt", m_cnt, lit_cnt);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic apply(input logic [1:0] sel, input logic bt, input logic [31:0] pcd,
                         input logic [15:0] i16, input logic [25:0] i26,
                         input logic [31:0] rs, input logic st, input logic rst);
        npc_sel  = sel;
        br_taken = bt;
        pc_d     = pcd;
        imm16    = i16;
        imm26    = i26;
        rs_val   = rs;
        stall    = st;
        reset    = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic pin(input logic [31:0] p, input logic e, input logic [31:0] c,
                       input logic [31:0] l);
        lit_pc   = p;
        lit_err  = e;
        lit_cnt  = c;
        lit_link = l;
        lit_en   = 1'b1;
        @(negedge clk);
        #1;
        lit_en   = 1'b0;
    endtask

    initial begin
        // reset for two cycles
        apply(2'd0, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b1);
        apply(2'd0, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b1);
        chk_en = 1'b1;
        pin(32'h3000, 1'b0, 32'd0, 32'h8);

        // free-running sequential fetch
        apply(2'd0, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0); pin(32'h3004, 1'b0, 32'd1, 32'h8);
        apply(2'd0, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0); pin(32'h3008, 1'b0, 32'd2, 32'h8);
        apply(2'd0, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0); pin(32'h300C, 1'b0, 32'd3, 32'h8);

        // branch taken backward, then not taken
        apply(2'd1, 1'b1, 32'h3010, 16'hFFFC, 26'h0, 32'h0, 1'b0, 1'b0); pin(32'h3004, 1'b0, 32'd4, 32'h3018);
        apply(2'd1, 1'b0, 32'h3010, 16'hFFFC, 26'h0, 32'h0, 1'b0, 1'b0); pin(32'h3008, 1'b0, 32'd5, 32'h3018);

        // J/JAL
        apply(2'd2, 1'b0, 32'h3FFC, 16'h0, 26'h0001000, 32'h0, 1'b0, 1'b0); pin(32'h4000, 1'b0, 32'd6, 32'h4004);

        // register jumps: misaligned, above window, top of window, bottom, below
        apply(2'd3, 1'b0, 32'h3FFC, 16'h0, 26'h0, 32'h3006, 1'b0, 1'b0); pin(32'h4180, 1'b1, 32'd7, 32'h4004);
        apply(2'd0, 1'b0, 32'h3FFC, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0);    pin(32'h4184, 1'b0, 32'd8, 32'h4004);
        apply(2'd3, 1'b0, 32'h3FFC, 16'h0, 26'h0, 32'h7000, 1'b0, 1'b0); pin(32'h4180, 1'b1, 32'd9, 32'h4004);
        apply(2'd0, 1'b0, 32'h3FFC, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0);    pin(32'h4184, 1'b0, 32'd10, 32'h4004);
        apply(2'd3, 1'b0, 32'h3FFC, 16'h0, 26'h0, 32'h6FFC, 1'b0, 1'b0); pin(32'h6FFC, 1'b0, 32'd11, 32'h4004);
        // sequential past TEXT_HI is not checked
        apply(2'd0, 1'b0, 32'h3FFC, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0);    pin(32'h7000, 1'b0, 32'd12, 32'h4004);
        apply(2'd3, 1'b0, 32'h3FFC, 16'h0, 26'h0, 32'h3000, 1'b0, 1'b0); pin(32'h3000, 1'b0, 32'd13, 32'h4004);
        apply(2'd3, 1'b0, 32'h3FFC, 16'h0, 26'h0, 32'h2FFC, 1'b0, 1'b0); pin(32'h4180, 1'b1, 32'd14, 32'h4004);

        // stall with a pending jump: hold, pulse drops, jump dropped
        repeat (3) begin
            apply(2'd2, 1'b0, 32'h3FFC, 16'h0, 26'h0001000, 32'h0, 1'b1, 1'b0);
            pin(32'h4180, 1'b0, 32'd14, 32'h4004);
        end
        apply(2'd2, 1'b0, 32'h3FFC, 16'h0, 26'h0001000, 32'h0, 1'b0, 1'b0); pin(32'h4000, 1'b0, 32'd15, 32'h4004);

        // reset wins over stall and a redirect; then resume out of stall
        apply(2'd3, 1'b0, 32'h3FFC, 16'h0, 26'h0, 32'h6FFC, 1'b1, 1'b1);    pin(32'h3000, 1'b0, 32'd0, 32'h4004);
        apply(2'd2, 1'b0, 32'h3FFC, 16'h0, 26'h0001000, 32'h0, 1'b1, 1'b0); pin(32'h3000, 1'b0, 32'd0, 32'h4004);
        apply(2'd0, 1'b0, 32'h3FFC, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0);       pin(32'h3004, 1'b0, 32'd1, 32'h4004);

        // branch to misaligned target, branch below window, untaken branch
        apply(2'd1, 1'b1, 32'h3002, 16'h0001, 26'h0, 32'h0, 1'b0, 1'b0); pin(32'h4180, 1'b1, 32'd2, 32'h300A);
        apply(2'd1, 1'b1, 32'h3000, 16'hFFFE, 26'h0, 32'h0, 1'b0, 1'b0); pin(32'h4180, 1'b1, 32'd3, 32'h3008);
        apply(2'd1, 1'b0, 32'h3000, 16'hFFFE, 26'h0, 32'h0, 1'b0, 1'b0); pin(32'h4184, 1'b0, 32'd4, 32'h3008);

        // mixed vectors checked by the model only
        for (int i = 0; i < 24; i++) begin
            apply(2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
                  32'h3000 + 32'($urandom_range(16'h3FFF, 0)),
                  16'($urandom_range(16'hFFFF, 0)), 26'($urandom_range(32'h0000_1BFF, 0)),
                  32'h2FF0 + 32'($urandom_range(16'h4020, 0)),
                  1'($urandom_range(3, 0) == 0), 1'b0);
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter PC_RESET, 32'h0000_3000, PC value loaded on reset.
REQ-002 Parameter EXC_VEC, 32'h0000_4180, PC loaded on an illegal redirect target.
REQ-003 Parameter TEXT_LO, 32'h0000_3000, lowest legal redirect target (inclusive).
REQ-004 Parameter TEXT_HI, 32'h0000_6FFC, highest legal redirect target (inclusive).
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 stall  in  1  1 = hold pc and fetch_cnt, ignore npc_sel.
REQ-008 npc_sel  in  2  00 sequential, 01 branch, 10 jump (J/JAL), 11 register jump (JR/JALR).
REQ-009 br_taken  in  1  branch comparison result from D stage; used only when npc_sel=01.
REQ-010 pc_d  in  32  PC of the instruction currently in D stage.
REQ-011 imm16  in  16  branch offset field of the D-stage instruction.
REQ-012 imm26  in  26  jump index field of the D-stage instruction.
REQ-013 rs_val  in  32  forwarded GPR[rs] for register jumps.
REQ-014 pc  out  32  registered fetch address for IF stage.
REQ-015 pc_link  out  32  combinational pc_d + 8, the link value for JAL/JALR.
REQ-016 addr_err  out  1  registered one-cycle pulse on an illegal redirect target.
REQ-017 fetch_cnt  out  32  registered count of PC updates.

Function
REQ-018 The block SHALL compute seq = pc + 4 and base = pc_d + 4, both modulo 2^32.
REQ-019 npc_sel=00 SHALL select target seq.
REQ-020 npc_sel=01 SHALL select base + (sign-extended imm16 << 2) when br_taken=1, and seq when br_taken=0 (not a redirect).
REQ-021 npc_sel=10 SHALL select {base[31:28], imm26, 2'b00}.
REQ-022 npc_sel=11 SHALL select rs_val unmodified.
REQ-023 A redirect is npc_sel=10, npc_sel=11, or npc_sel=01 with br_taken=1.
REQ-024 A redirect target is illegal when target[1:0]!=0, target<TEXT_LO, or target>TEXT_HI (unsigned compare).
REQ-025 On each rising edge with reset=0 and stall=0: pc SHALL load EXC_VEC for an illegal redirect target, else the selected target.
REQ-026 Under the same conditions, addr_err SHALL load 1 for an illegal redirect target, else 0.
REQ-027 Under the same conditions, fetch_cnt SHALL increment by 1, wrapping 32'hFFFF_FFFF -> 0.
REQ-028 With stall=1 and reset=0: pc and fetch_cnt SHALL hold; addr_err SHALL load 0 (the pulse never stretches).
REQ-029 Sequential targets SHALL NOT be range-checked; pc may advance past TEXT_HI without error.
REQ-030 Latency: the new pc SHALL be visible the cycle after the controlling inputs are sampled; no internal pending-redirect storage. A redirect asserted under stall SHALL be dropped, and the D stage re-presents it.
REQ-031 pc_link SHALL be combinational from pc_d only, independent of stall and reset.

Reset
REQ-032 reset=1 at a rising edge SHALL set pc=PC_RESET, addr_err=0, fetch_cnt=0, overriding stall and any redirect in the same cycle.
REQ-033 Reset deasserted mid-stall SHALL resume with pc=PC_RESET on the first non-stalled edge, then advance normally.

Verification
REQ-034 Reset 2 cycles, then 3 free cycles with npc_sel=00 -> pc = 3000, 3004, 3008, 300C; fetch_cnt=3; addr_err=0.
REQ-035 pc_d=0000_3010, npc_sel=01, imm16=FFFC, br_taken=1 -> next pc=0000_3004. Same with br_taken=0 -> pc+4, addr_err=0.
REQ-036 pc_d=0000_3FFC, npc_sel=10, imm26=000_1000 -> pc=0000_4000; pc_link=0000_4004.
REQ-037 npc_sel=11, rs_val=0000_3006 -> pc=0000_4180 and addr_err=1 for exactly one cycle. Repeat with rs_val=0000_7000 -> same result. With rs_val=0000_6FFC -> pc=0000_6FFC, no error.
REQ-038 stall=1 for 3 cycles with npc_sel=10 -> pc and fetch_cnt unchanged, addr_err=0. Release stall -> jump taken on the next edge. Stall plus reset together -> pc=0000_3000.
